// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: register offsets, STATUS layout,
// default window base and the STATUS word packer.
package dmem_mmio_pkg;

  localparam logic [7:0] OFS_TXDATA = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h04;
  localparam logic [7:0] OFS_CYCLES = 8'h08;
  localparam logic [7:0] OFS_DROPS  = 8'h0C;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_COUNT_LSB = 2;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  function automatic logic [31:0] status_word(logic [4:0] count, logic full, logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_COUNT_LSB +: 5] = count;
    w[ST_FULL]           = full;
    w[ST_EMPTY]          = empty;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted only when a pop happens
// in the same cycle. No fall-through: a pushed byte is visible the following cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = empty_o ? 8'h00 : mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (!do_push && do_pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // When full with a pop, wptr equals rptr: the slot being read out is the one overwritten.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage for the single-cycle core: word RAM plus an MMIO window holding
// a console byte FIFO, a free-running cycle counter and a saturating drop counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int unsigned IdxW = $clog2(RAM_WORDS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     mem_q [RAM_WORDS];
  logic [31:0]     cycles_q, cycles_d;
  logic [15:0]     drops_q, drops_d;

  logic            is_io, io_we;
  logic [7:0]      ofs;
  logic [IdxW-1:0] idx;
  logic            fifo_full, fifo_empty, pop, push_req, drop;
  logic [CntW-1:0] fifo_count;

  assign is_io = (a >= MMIO_BASE);
  assign ofs   = {a[7:2], 2'b00};
  assign idx   = a[IdxW+1:2];
  assign io_we = we && is_io;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push_req  = io_we && (ofs == OFS_TXDATA);
  assign drop      = push_req && fifo_full && !pop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (wd[7:0]),
    .dout_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (io_we && (ofs == OFS_CYCLES)) cycles_d = wd;

    drops_d = drops_q;
    // A clear racing a drop keeps the drop that happened this cycle.
    if (io_we && (ofs == OFS_DROPS))        drops_d = drop ? 16'd1 : 16'd0;
    else if (drop && drops_q != 16'hFFFF)   drops_d = drops_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
      drops_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      drops_q  <= drops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !is_io) mem_q[idx] <= wd;
  end

  always_comb begin
    rd = '0;
    if (is_io) begin
      case (ofs)
        OFS_STATUS: rd = status_word(5'(fifo_count), fifo_full, fifo_empty);
        OFS_CYCLES: rd = cycles_q;
        OFS_DROPS:  rd = {16'b0, drops_q};
        default:    rd = '0;
      endcase
    end else begin
      rd = mem_q[idx];
    end
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle MIPS core. It consumes the core's memwrite, aluout and writedata, and returns readdata.
- Provides a word-addressed data RAM and a small memory-mapped I/O window.
- The I/O window holds:
  - a byte output FIFO drained by a valid/ready consumer (console/UART);
  - a free-running cycle counter;
  - a status register and a drop counter.

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8, output FIFO depth in bytes; power of two, minimum 2.
- MMIO_BASE, 32'hFFFF_FF00, base address of the I/O window (256-byte aligned).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable (core memwrite).
- a  in  32  byte address (core aluout).
- wd  in  32  write data (core writedata).
- rd  out  32  read data (core readdata); combinational.
- out_valid  out  1  FIFO has a byte for the consumer.
- out_data  out  8  byte at the FIFO head.
- out_ready  in  1  consumer accepts the byte this cycle.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. All state updates on the rising edge of clk.
- Address decode: a[1:0] is ignored (word access only).
  - a >= MMIO_BASE: I/O. Offset is a[7:0].
  - Otherwise: RAM. Index is a[log2(RAM_WORDS)+1:2]; upper bits are ignored, so addresses alias modulo the RAM size.
- Read path: rd is purely combinational from a and current state. There is zero-cycle latency, because the core is single-cycle.
- RAM write: when we, mem[index] <= wd at the clock edge. RAM is not cleared by reset.
- MMIO map:
  - 0x00 TXDATA: a write pushes wd[7:0]. Reads return 0.
  - 0x04 STATUS: reads return {zeros, count[4:0] at bits 6:2, full at bit 1, empty at bit 0}. Writes are ignored.
  - 0x08 CYCLES: reads return the 32-bit counter. A write loads wd.
  - 0x0C DROPS: reads return {16'b0, drops[15:0]}. Any write clears it to 0.
  - Any other offset reads 0; writes to it are ignored.
- FIFO:
  - out_valid = !empty. out_data = head byte, or 0 when empty.
  - pop = out_valid & out_ready.
  - push_req = we & TXDATA hit.
  - A push is accepted if !full, or if pop occurs in the same cycle; full with a simultaneous pop accepts both.
  - Empty with a simultaneous push: the byte appears on out_valid next cycle. There is no fall-through.
  - A rejected push (full and no pop) increments drops, which saturates at 16'hFFFF. The byte is lost.
  - Read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- CYCLES:
  - Increments by 1 every cycle and wraps from 2^32-1 to 0.
  - A write has priority: the register becomes wd that cycle, then increments from the next cycle.
- DROPS: a clear-write and a drop in the same cycle result in 1.
- Reset values:
  - FIFO empty: pointers and count 0, out_valid 0, out_data 0.
  - CYCLES 0, DROPS 0.
  - rd follows the decode, so STATUS reads 32'h1 in reset.
- Reset mid-operation: queued bytes are discarded. A push or pop in the reset cycle is ignored.

Decomposition:
- Shared package dmem_mmio_pkg holds:
  - MMIO offset constants: OFS_TXDATA, OFS_STATUS, OFS_CYCLES, OFS_DROPS;
  - STATUS bit positions: ST_EMPTY, ST_FULL, ST_COUNT_LSB;
  - the default MMIO_BASE.
- One sub-module, byte_fifo: a synchronous FIFO parameterised by DEPTH, with push, pop, din, dout, full, empty and count. dmem_mmio instantiates it once.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x40, then read 0x40 and 0x43 -> rd = 32'hDEADBEEF both times. With RAM_WORDS=64, a read of 0x140 also returns 32'hDEADBEEF (alias).
- FIFO basic: with out_ready=0, push 0x41, 0x42 to MMIO_BASE+0x00.
  - STATUS reads 32'h8: count 2, empty 0.
  - Raise out_ready: out_data is 0x41 then 0x42 on consecutive cycles, then out_valid=0 and STATUS=32'h1.
- Overflow: with out_ready=0, push 10 bytes 0x00..0x09.
  - STATUS reads count 8, full=1.
  - DROPS reads 2.
  - Draining yields 0x00..0x07 only.
- Full + simultaneous push/pop: with the FIFO full and out_ready=1, push 0xAA.
  - Count stays 8 and DROPS is unchanged.
  - 0xAA emerges last, after the 7 remaining bytes.
- CYCLES: read twice 5 cycles apart -> difference 5. Write 32'hFFFF_FFFE -> reads FFFFFFFE, FFFFFFFF, 00000000 on the next three cycles.
- Reset mid-operation: with 3 bytes queued and DROPS=4, assert reset for 1 cycle -> out_valid=0, STATUS=32'h1, DROPS=0, CYCLES=0. RAM contents are preserved.
